// File: rtl/fsm_stream_arb.sv
// Round-robin arbiter sharing one serial pattern detector between NUM_REQ bit-stream requesters.
// Optional stream-length watchdog enabled by defining FSM_ARB_TIMEOUT_EN.
module fsm_stream_arb #(
   parameter int NUM_REQ = 2,
   parameter int CNT_W   = 8,
   parameter int MAX_LEN = 64
) (
   input  logic               clk,
   input  logic               areset,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] bit_in,
   input  logic [NUM_REQ-1:0] last,
   input  logic               out_fsm,
   output logic [NUM_REQ-1:0] grant,
   output logic               fsm_in,
   output logic               fsm_rst,
   output logic               busy,
   output logic               done,
   output logic               abort,
   output logic [CNT_W-1:0]   hit_cnt
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t               state_reg, state_next;
   logic [IDX_W-1:0]     gnt_idx_reg, gnt_idx_next;
   logic [IDX_W-1:0]     ptr_reg, ptr_next;
   logic [NUM_REQ-1:0]   grant_reg, grant_next;
   logic                 fsm_rst_reg, fsm_rst_next;
   logic                 busy_reg, busy_next;
   logic                 done_reg, done_next;
   logic                 abort_reg, abort_next;
   logic [CNT_W-1:0]     hit_cnt_reg, hit_cnt_next;

   logic [IDX_W-1:0]     win_idx;
   logic                 win_found;
   logic [NUM_REQ-1:0]   win_onehot;
   logic                 req_g, bit_g, last_g;
   logic                 timeout;

   if (NUM_REQ < 2 || NUM_REQ > 8 || CNT_W < 1 || MAX_LEN < 1) begin : g_bad_param
      $error("fsm_stream_arb: parameter out of range");
   end

   assign req_g  = req[gnt_idx_reg];
   assign bit_g  = bit_in[gnt_idx_reg];
   assign last_g = last[gnt_idx_reg];

   // Search upward from the requester after the last-granted one, wrapping around.
   always_comb begin : p_win
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      cand      = 0;
      cand_idx  = '0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(ptr_reg) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!win_found && req[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   genvar gi;
   for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_idx == IDX_W'(gi));
   end

`ifdef FSM_ARB_TIMEOUT_EN
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic [LEN_W-1:0] len_cnt_reg, len_cnt_next;

   always_comb begin
      len_cnt_next = len_cnt_reg;
      if (state_reg == CLEAR) begin
         len_cnt_next = '0;
      end else if (state_reg == STREAM && len_cnt_reg != LEN_W'(MAX_LEN)) begin
         len_cnt_next = len_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (areset) begin
         len_cnt_reg <= '0;
      end else begin
         len_cnt_reg <= len_cnt_next;
      end
   end

   // Fires on the MAX_LEN-th STREAM cycle.
   assign timeout = (state_reg == STREAM) && (len_cnt_reg == LEN_W'(MAX_LEN - 1));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_next   = state_reg;
      gnt_idx_next = gnt_idx_reg;
      ptr_next     = ptr_reg;
      grant_next   = grant_reg;
      abort_next   = 1'b0;
      hit_cnt_next = hit_cnt_reg;
      fsm_in       = 1'b0;

      // DONE is included so the detector's response to the final bit is counted.
      if ((state_reg == STREAM || state_reg == DONE) && out_fsm && hit_cnt_reg != '1) begin
         hit_cnt_next = hit_cnt_reg + 1'b1;
      end

      case (state_reg)
         IDLE: begin
            if (win_found) begin
               state_next   = CLEAR;
               gnt_idx_next = win_idx;
               grant_next   = win_onehot;
               hit_cnt_next = '0;
            end
         end
         CLEAR: begin
            state_next = STREAM;
         end
         STREAM: begin
            fsm_in = req_g & bit_g;
            if (!req_g) begin
               state_next = DONE;
               abort_next = 1'b1;
            end else if (last_g) begin
               state_next = DONE;
            end else if (timeout) begin
               state_next = DONE;
               abort_next = 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
            ptr_next   = gnt_idx_reg;
            grant_next = '0;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      fsm_rst_next = (state_next == CLEAR);
      busy_next    = (state_next != IDLE);
      done_next    = (state_next == DONE);
   end

   always_ff @(posedge clk) begin
      if (areset) begin
         state_reg   <= IDLE;
         gnt_idx_reg <= '0;
         ptr_reg     <= IDX_W'(NUM_REQ - 1);
         grant_reg   <= '0;
         fsm_rst_reg <= 1'b1;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         abort_reg   <= 1'b0;
         hit_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         gnt_idx_reg <= gnt_idx_next;
         ptr_reg     <= ptr_next;
         grant_reg   <= grant_next;
         fsm_rst_reg <= fsm_rst_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         abort_reg   <= abort_next;
         hit_cnt_reg <= hit_cnt_next;
      end
   end

   assign grant   = grant_reg;
   assign fsm_rst = fsm_rst_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;
   assign abort   = abort_reg;
   assign hit_cnt = hit_cnt_reg;

endmodule

// File: tb/tb_fsm_stream_arb.sv
// Randomized bench for fsm_stream_arb: per-stream expectations come from a transaction-level model
// (round-robin winner by arithmetic, hit count = ones forwarded, saturated). Honors FSM_ARB_TIMEOUT_EN.
module tb_fsm_stream_arb;

   localparam int N  = 3;
   localparam int CW = 4;
   localparam int ML = 4;
   localparam int SAT = (1 << CW) - 1;

   logic           clk;
   logic           areset;
   logic [N-1:0]   req;
   logic [N-1:0]   bit_in;
   logic [N-1:0]   last;
   logic           out_fsm;
   logic [N-1:0]   grant;
   logic           fsm_in;
   logic           fsm_rst;
   logic           busy;
   logic           done;
   logic           abort;
   logic [CW-1:0]  hit_cnt;

   fsm_stream_arb #(
      .NUM_REQ (N),
      .CNT_W   (CW),
      .MAX_LEN (ML)
   ) dut (
      .clk     (clk),
      .areset  (areset),
      .req     (req),
      .bit_in  (bit_in),
      .last    (last),
      .out_fsm (out_fsm),
      .grant   (grant),
      .fsm_in  (fsm_in),
      .fsm_rst (fsm_rst),
      .busy    (busy),
      .done    (done),
      .abort   (abort),
      .hit_cnt (hit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Detector stand-in: Moore machine whose output is the previous input bit.
   logic det_q;
   always @(posedge clk) begin
      if (fsm_rst) det_q <= 1'b0;
      else         det_q <= fsm_in;
   end
   assign out_fsm = det_q;

   int checks = 0;
   int errors = 0;

   logic [N-1:0] pend;
   int           len_a   [N];
   logic [31:0]  bits_a  [N];
   int           abort_a [N];
   bit           lastab_a[N];
   int           ptr_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic prep(input int r, input int len, input logic [31:0] bits, input int ab, input bit lab);
      len_a[r]    = len;
      bits_a[r]   = bits;
      abort_a[r]  = ab;
      lastab_a[r] = lab;
   endtask

   task automatic prep_rand(input int r);
      int len;
      int ab;
      len = $urandom_range(1, 6);
      ab  = -1;
      if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, len - 1);
      prep(r, len, $urandom, ab, 1'($urandom_range(0, 1)));
   endtask

   task automatic drive_idle();
      req    = pend;
      bit_in = N'($urandom);
      last   = N'($urandom);
   endtask

   // Serves one stream: expects the round-robin winner among pending requesters, then checks
   // the stream, the done/abort pulse and the saturated hit count. 'arrive' requesters post new
   // requests during the DONE cycle.
   task automatic serve_one(input logic [N-1:0] arrive);
      int   w, c, lim, end_i, ones;
      bit   drop, exp_ab, got, tmo, cut;
      logic exp_bit;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(posedge clk); #1;
         drive_idle();
         #1;
         if (grant != '0) got = 1'b1;
      end
      if (!got) begin
         check("grant_wait", 32'(grant), 32'(pend));
         return;
      end
      w = -1;
      for (int k = 1; k <= N; k++) begin
         c = (ptr_m + k) % N;
         if (w < 0 && pend[c]) w = c;
      end
      check("clear_grant", 32'(grant), (w < 0) ? 32'd0 : (32'd1 << w));
      if (w < 0) return;
      check("clear_rst", 32'(fsm_rst), 1);
      check("clear_fsm_in", 32'(fsm_in), 0);
      check("clear_busy", 32'(busy), 1);

      lim = len_a[w] - 1;
      tmo = 1'b0;
`ifdef FSM_ARB_TIMEOUT_EN
      if (lim > ML - 1) begin
         lim = ML - 1;
         tmo = 1'b1;
      end
`endif
      drop   = (abort_a[w] >= 0) && (abort_a[w] <= lim);
      end_i  = drop ? abort_a[w] : lim;
      exp_ab = drop | tmo;
      ones   = 0;

      for (int i = 0; i <= end_i; i++) begin
         @(posedge clk); #1;
         for (int r = 0; r < N; r++) req[r] = pend[r] | ($urandom_range(0, 3) == 0);
         bit_in = N'($urandom);
         last   = N'($urandom);
         cut    = drop && (i == end_i);
         bit_in[w] = bits_a[w][i];
         last[w]   = (i == len_a[w] - 1) || (cut && lastab_a[w]);
         req[w]    = !cut;
         #1;
         exp_bit = cut ? 1'b0 : bits_a[w][i];
         if (!cut) ones += int'(bits_a[w][i]);
         check("stream_fsm_in", 32'(fsm_in), 32'(exp_bit));
         check("stream_grant", 32'(grant), 32'd1 << w);
         check("stream_done", 32'(done), 0);
         check("stream_rst", 32'(fsm_rst), 0);
      end

      @(posedge clk); #1;
      pend[w] = 1'b0;
      for (int r = 0; r < N; r++) begin
         if (arrive[r] && !pend[r]) begin
            prep_rand(r);
            pend[r] = 1'b1;
         end
      end
      drive_idle();
      #1;
      check("done_pulse", 32'(done), 1);
      check("done_abort", 32'(abort), 32'(exp_ab));
      check("done_grant", 32'(grant), 32'd1 << w);
      check("done_fsm_in", 32'(fsm_in), 0);

      @(posedge clk); #2;
      check("idle_done", 32'(done), 0);
      check("idle_grant", 32'(grant), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_hits", 32'(hit_cnt), (ones > SAT) ? SAT : ones);
      ptr_m = w;
      $display("txn req=%0d cycles=%0d abort=%0b hits=%0d", w, end_i + 1, exp_ab, (ones > SAT) ? SAT : ones);
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && pend != '0; k++) serve_one('0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ptr_m  = N - 1;
      pend   = '0;
      areset = 1'b1;
      req    = '1;
      bit_in = '1;
      last   = '0;

      // Reset
      repeat (2) @(posedge clk);
      #1;
      check("rst_fsm_rst", 32'(fsm_rst), 1);
      check("rst_grant", 32'(grant), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_hits", 32'(hit_cnt), 0);
      check("rst_done", 32'(done), 0);
      check("rst_abort", 32'(abort), 0);
      check("rst_fsm_in", 32'(fsm_in), 0);
      areset = 1'b0;
      req    = '0;
      @(posedge clk); #1;
      check("post_rst_fsm_rst", 32'(fsm_rst), 0);
      check("post_rst_grant", 32'(grant), 0);
      #1;

      // Single stream 0,1,0,0 from requester 0
      prep(0, 4, 32'h2, -1, 1'b0);
      pend = 3'b001;
      drive_idle();
      serve_one('0);

      // Contention with re-arming requesters
      prep(0, 3, $urandom, -1, 1'b0);
      prep(1, 3, $urandom, -1, 1'b0);
      pend = 3'b011;
      drive_idle();
      repeat (3) serve_one(3'b011);
      drain();

      // Abort of requester 1 after two bits, requester 0 arrives meanwhile
      prep(1, 5, 32'h1F, 2, 1'b0);
      pend = 3'b010;
      drive_idle();
      serve_one(3'b001);
      serve_one('0);
      drain();

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         if (pend == '0) begin
            pend = N'($urandom_range(1, (1 << N) - 1));
            for (int r = 0; r < N; r++) if (pend[r]) prep_rand(r);
            drive_idle();
         end
         serve_one(N'($urandom));
      end
      drain();

      // Hit counter saturation
      prep(2, 20, 32'hFFFFF, -1, 1'b0);
      pend = 3'b100;
      drive_idle();
      serve_one('0);

`ifdef FSM_ARB_TIMEOUT_EN
      // Stream without last: ends through the length watchdog
      prep(0, 30, 32'hFFFF_FFFF, -1, 1'b0);
      pend = 3'b001;
      drive_idle();
      serve_one('0);
`endif

      // Reset in the middle of a stream
      prep(0, 30, 32'hFFFF_FFFF, -1, 1'b0);
      pend = 3'b001;
      drive_idle();
      @(posedge clk); #1;
      drive_idle();
      #1;
      check("mr_clear_grant", 32'(grant), 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         req    = pend;
         bit_in = '1;
         last   = '0;
         #1;
      end
      @(posedge clk); #1;
      areset = 1'b1;
      #1;
      check("mr_hits_before", 32'(hit_cnt), 2);
      check("mr_busy_before", 32'(busy), 1);
      @(posedge clk); #1;
      check("mr_grant", 32'(grant), 0);
      check("mr_busy", 32'(busy), 0);
      check("mr_done", 32'(done), 0);
      check("mr_hits", 32'(hit_cnt), 0);
      check("mr_fsm_rst", 32'(fsm_rst), 1);
      areset = 1'b0;
      pend   = '0;
      req    = '0;
      ptr_m  = N - 1;
      @(posedge clk); #1;
      check("mr_release_rst", 32'(fsm_rst), 0);
      #1;

      // Pointer restored by reset: requester 0 wins again
      prep(0, 3, $urandom, -1, 1'b0);
      prep(1, 3, $urandom, -1, 1'b0);
      pend = 3'b011;
      drive_idle();
      serve_one('0);
      serve_one('0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
